dma_channel_scheduler: RTL and testbench
========================================

# dma_channel_scheduler

Multi-channel front end for the single-engine `dma_master`. It latches up to NUM_CH independent transfer descriptors from requesters and picks one pending channel round-robin. It drives that channel's src/dst/len/burst and a one-cycle start pulse into `dma_master`, waits for completion, then retires the channel with per-channel done/error indications. The block sits between the CPU-facing register file and `dma_master`, and serialises all channels onto the one AXI master.

## Interface
- NUM_CH, 4: number of requester channels (2..16).
- ADDR_WIDTH, 32: descriptor address width.
- DATA_WIDTH, 32: width of the `dma_master` config registers.
- TIMEOUT_CYCLES, 4096: watchdog limit in WAIT (used only with the macro).

- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_CH  per-channel descriptor offer.
- req_ready  out  NUM_CH  per-channel accept; equals !pending[i].
- req_src  in  NUM_CH*ADDR_WIDTH  flattened source addresses; channel i is at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_dst  in  NUM_CH*ADDR_WIDTH  flattened destination addresses.
- req_len  in  NUM_CH*8  beat count per channel (1..255).
- req_burst  in  NUM_CH*2  AXI burst type per channel.
- dma_src_reg, dma_dst_reg, dma_len_reg, dma_ctrl_reg  out  DATA_WIDTH each  drive into `dma_master`.
- dma_burst_reg  out  2  burst into `dma_master`.
- dma_done  in  1  `dma_master` completion (level; stays high until the next start).
- dma_err  in  1  `dma_master` error status; valid whenever dma_done is high.
- ch_done  out  NUM_CH  one-cycle retire pulse.
- ch_err  out  NUM_CH  sticky per-channel error; cleared when that channel's next request is accepted.
- busy  out  1  high in every state except IDLE.
- active_ch  out  $clog2(NUM_CH)  channel currently granted.

## Operation
- **Accept.** A descriptor is accepted on req_valid[i] && req_ready[i]. On acceptance the descriptor is copied into that channel's shadow registers and pending[i] is set.
- **Zero length.** A request with req_len = 0 is accepted, but the channel is never launched. It retires on the next IDLE pass with ch_done[i] pulsed and ch_err[i] set.
- **FSM states:** IDLE, LAUNCH, WAIT, RETIRE.
- **IDLE.**
  - With no channel pending, stay in IDLE.
  - Otherwise the round-robin pick is the first pending channel at or after rr_ptr, wrapping modulo NUM_CH.
  - Register the pick into active_ch and load dma_* from that channel's shadow.
  - Go to LAUNCH, or to RETIRE if the picked channel has length 0.
- **LAUNCH.** dma_ctrl_reg[CTRL_START_BIT] = 1 for exactly this cycle. Go to WAIT.
- **WAIT.**
  - Completion is detected on the rising edge of dma_done (dma_done && !done_q). This prevents the stale high done left over from the previous transfer from retiring the new one.
  - On detection, latch dma_err and go to RETIRE.
- **RETIRE.**
  - Pulse ch_done[active_ch] and set ch_err[active_ch] if an error was latched.
  - Clear pending[active_ch].
  - Set rr_ptr = active_ch+1, wrapping to 0 at NUM_CH.
  - Go to IDLE.
- **Hold.** dma_src/dst/len/burst hold their values from LAUNCH until the next IDLE grant.
- **Widths.** dma_len_reg and dma_burst_reg are zero-extended into the DATA_WIDTH-wide config registers. Addresses are truncated or zero-extended to DATA_WIDTH.
- **Same-cycle accept and retire.** A request on a channel that is retiring this cycle is not accepted, because req_ready is still low. req_ready rises in the cycle after RETIRE.
- **Simultaneous offers.** Any number of channels can be accepted in the same cycle. The grant order is determined purely by rr_ptr.
- **Reset** (asynchronous, at any point including mid-transfer):
  - State goes to IDLE.
  - pending, ch_done, ch_err, rr_ptr, active_ch, all dma_* outputs, busy and done_q go to 0.
  - Shadow registers need not be reset.

## Timing
- Accept at cycle 0 → pending at cycle 1 → grant in IDLE at cycle 1 → start pulse at cycle 2 (LAUNCH).
- dma_done rising seen at cycle M (in WAIT) → RETIRE at M+1 (ch_done pulse) → IDLE at M+2 → next start pulse at M+3 at the earliest.
- busy is high from LAUNCH through RETIRE inclusive.

## Configuration
- **Macro:** `DMA_SCHED_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without a done edge, the FSM goes to RETIRE with the error forced: ch_err set, ch_done pulsed.
  - An extra output `timeout_flag` (1 bit) is sticky until reset.
- **Undefined:** WAIT waits indefinitely, and neither the counter nor the `timeout_flag` port exists.

## Structure
- Package `dma_pkg` holds:
  - CTRL_START_BIT = 0, STATUS_DONE_BIT = 0, STATUS_ERR_BIT = 1;
  - AXI burst encodings (FIXED = 0, INCR = 1, WRAP = 2);
  - the `sched_state_t` enum.
- Sub-module `dma_rr_arbiter`: a combinational round-robin picker.
  - Inputs: pending vector and rr_ptr.
  - Outputs: grant index and any_pending.

## Test plan
- **Single channel.** Channel 1 with src=0x1000, dst=0x2000, len=4, burst=INCR. Expect a start pulse 2 cycles after accept, dma_len_reg=4 and active_ch=1. Raise dma_done 10 cycles later → ch_done[1] 1 cycle later, ch_err[1]=0.
- **Round-robin.** Channels 0, 2 and 3 offered in the same cycle with rr_ptr=0. Expect launches in order 0, 2, 3. Then re-offer channel 0 together with channel 3 → channel 3 is launched before channel 0.
- **Stale done.** Hold dma_done high from the previous transfer through the next LAUNCH. Expect no retire until dma_done falls and rises again.
- **Error and zero length.** dma_err=1 at a done edge for channel 2 → ch_err[2]=1, cleared on channel 2's next accept. A req_len=0 request on channel 3 → ch_done[3] and ch_err[3] with no start pulse.
- **Reset mid-transfer.** ARESETN low during WAIT → busy, pending, dma_ctrl_reg and ch_err all read 0 immediately. After reset release there is no start pulse.
- **Timeout** (`DMA_SCHED_TIMEOUT_EN`, TIMEOUT_CYCLES=16). No dma_done after launch → RETIRE in the 16th WAIT cycle, with ch_err set and timeout_flag=1.

Source files
------------

// File: rtl/dma_channel_scheduler_pkg.sv
// ============================================================================
//  Module   : dma_pkg
//  Purpose  : Shared constants, AXI burst encodings and FSM state type for the
//             multi-channel DMA scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_pkg;

    localparam int CTRL_START_BIT  = 0;
    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_ERR_BIT  = 1;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RETIRE = 2'd3
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/dma_channel_scheduler_if.sv
// ============================================================================
//  Module   : dma_channel_scheduler_if
//  Purpose  : Requester descriptor bus, dma_master config/status bus and the
//             per-channel status outputs of the scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dma_channel_scheduler_if #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]            req_valid;
    logic [NUM_CH-1:0]            req_ready;
    logic [NUM_CH*ADDR_WIDTH-1:0] req_src;
    logic [NUM_CH*ADDR_WIDTH-1:0] req_dst;
    logic [NUM_CH*8-1:0]          req_len;
    logic [NUM_CH*2-1:0]          req_burst;

    logic [DATA_WIDTH-1:0]        dma_src_reg;
    logic [DATA_WIDTH-1:0]        dma_dst_reg;
    logic [DATA_WIDTH-1:0]        dma_len_reg;
    logic [DATA_WIDTH-1:0]        dma_ctrl_reg;
    logic [1:0]                   dma_burst_reg;
    logic                         dma_done;
    logic                         dma_err;

    logic [NUM_CH-1:0]            ch_done;
    logic [NUM_CH-1:0]            ch_err;
    logic                         busy;
    logic [CH_W-1:0]              active_ch;

    // Scheduler side
    modport master (
        input  req_valid, req_src, req_dst, req_len, req_burst,
        input  dma_done, dma_err,
        output req_ready,
        output dma_src_reg, dma_dst_reg, dma_len_reg, dma_ctrl_reg, dma_burst_reg,
        output ch_done, ch_err, busy, active_ch
    );

    // Requester / dma_master side
    modport slave (
        output req_valid, req_src, req_dst, req_len, req_burst,
        output dma_done, dma_err,
        input  req_ready,
        input  dma_src_reg, dma_dst_reg, dma_len_reg, dma_ctrl_reg, dma_burst_reg,
        input  ch_done, ch_err, busy, active_ch
    );

endinterface

`default_nettype wire

// File: rtl/dma_channel_scheduler_rr_arbiter.sv
// ============================================================================
//  Module   : dma_rr_arbiter
//  Purpose  : Combinational round-robin picker: first pending channel at or
//             after the pointer, wrapping modulo NUM_CH.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  wire [NUM_CH-1:0] i_pending,
    input  wire [CH_W-1:0]   i_rr_ptr,
    output logic [CH_W-1:0]  o_grant,
    output logic             o_any_pending
);

    // Walk offsets from farthest to nearest so the nearest pending channel wins
    always_comb begin
        o_grant = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_pending[(int'(i_rr_ptr) + i) % NUM_CH]) begin
                o_grant = CH_W'((int'(i_rr_ptr) + i) % NUM_CH);
            end
        end
    end

    assign o_any_pending = |i_pending;

endmodule

`default_nettype wire

// File: rtl/dma_channel_scheduler.sv
// ============================================================================
//  Module   : dma_channel_scheduler
//  Purpose  : Latches per-channel descriptors and serialises them round-robin
//             onto the single dma_master engine. Optional watchdog in WAIT is
//             enabled by defining DMA_SCHED_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_channel_scheduler
    import dma_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire                     ACLK,
    input  wire                     ARESETN,
`ifdef DMA_SCHED_TIMEOUT_EN
    output logic                    timeout_flag,
`endif
    dma_channel_scheduler_if.master bus
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    generate
        if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
            $error("dma_channel_scheduler: NUM_CH must be 2..16 and TIMEOUT_CYCLES >= 2");
        end
    endgenerate

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;

    logic [NUM_CH-1:0]     r_pending;
    logic [NUM_CH-1:0]     r_ch_err;
    logic [CH_W-1:0]       r_rr_ptr;
    logic [CH_W-1:0]       r_active_ch;
    logic                  r_done_q;
    logic                  r_err_lat;

    logic [DATA_WIDTH-1:0] r_dma_src;
    logic [DATA_WIDTH-1:0] r_dma_dst;
    logic [DATA_WIDTH-1:0] r_dma_len;
    logic [1:0]            r_dma_burst;

    logic [ADDR_WIDTH-1:0] r_src_sh   [NUM_CH];
    logic [ADDR_WIDTH-1:0] r_dst_sh   [NUM_CH];
    logic [7:0]            r_len_sh   [NUM_CH];
    logic [1:0]            r_burst_sh [NUM_CH];

    logic [NUM_CH-1:0]     w_accept;
    logic [NUM_CH-1:0]     w_retire_mask;
    logic [CH_W-1:0]       w_grant;
    logic                  w_any_pending;
    logic                  w_grant_zero;
    logic                  w_done_edge;
    logic                  w_timeout;
    logic [CH_W-1:0]       w_rr_next;

    dma_rr_arbiter #(
        .NUM_CH        (NUM_CH)
    ) u_arb (
        .i_pending     (r_pending),
        .i_rr_ptr      (r_rr_ptr),
        .o_grant       (w_grant),
        .o_any_pending (w_any_pending)
    );

    assign w_accept      = bus.req_valid & ~r_pending;
    assign w_retire_mask = (r_state == S_RETIRE) ? (NUM_CH'(1) << r_active_ch) : '0;
    assign w_grant_zero  = (r_len_sh[w_grant] == 8'd0);
    // Only a rising edge counts: done stays high from the previous transfer
    assign w_done_edge   = bus.dma_done & ~r_done_q;
    assign w_rr_next     = (r_active_ch == CH_W'(NUM_CH - 1)) ? '0 : r_active_ch + 1'b1;

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_timeout_flag;

    assign w_timeout = (r_state == S_WAIT) && (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_to_cnt       <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            if (r_state == S_LAUNCH) begin
                r_to_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout && !w_done_edge) begin
                r_timeout_flag <= 1'b1;
            end
        end
    end

    assign timeout_flag = r_timeout_flag;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_pending) begin
                    w_state_nxt = w_grant_zero ? S_RETIRE : S_LAUNCH;
                end
            end
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_done_edge || w_timeout) begin
                    w_state_nxt = S_RETIRE;
                end
            end
            S_RETIRE: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Descriptor shadows carry no reset; they are only read once pending is set
    always_ff @(posedge ACLK) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_accept[i]) begin
                r_src_sh[i]   <= bus.req_src[i*ADDR_WIDTH +: ADDR_WIDTH];
                r_dst_sh[i]   <= bus.req_dst[i*ADDR_WIDTH +: ADDR_WIDTH];
                r_len_sh[i]   <= bus.req_len[i*8 +: 8];
                r_burst_sh[i] <= bus.req_burst[i*2 +: 2];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_pending   <= '0;
            r_ch_err    <= '0;
            r_rr_ptr    <= '0;
            r_active_ch <= '0;
            r_done_q    <= 1'b0;
            r_err_lat   <= 1'b0;
            r_dma_src   <= '0;
            r_dma_dst   <= '0;
            r_dma_len   <= '0;
            r_dma_burst <= '0;
        end else begin
            r_done_q  <= bus.dma_done;
            r_pending <= (r_pending | w_accept) & ~w_retire_mask;
            r_ch_err  <= (r_ch_err & ~w_accept) | (r_err_lat ? w_retire_mask : '0);

            case (r_state)
                S_IDLE: begin
                    if (w_any_pending) begin
                        r_active_ch <= w_grant;
                        r_dma_src   <= DATA_WIDTH'(r_src_sh[w_grant]);
                        r_dma_dst   <= DATA_WIDTH'(r_dst_sh[w_grant]);
                        r_dma_len   <= DATA_WIDTH'(r_len_sh[w_grant]);
                        r_dma_burst <= r_burst_sh[w_grant];
                        r_err_lat   <= w_grant_zero;
                    end
                end
                S_WAIT: begin
                    if (w_done_edge) begin
                        r_err_lat <= bus.dma_err;
                    end else if (w_timeout) begin
                        r_err_lat <= 1'b1;
                    end
                end
                S_RETIRE: begin
                    r_rr_ptr <= w_rr_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready     = ~r_pending;
    assign bus.dma_src_reg   = r_dma_src;
    assign bus.dma_dst_reg   = r_dma_dst;
    assign bus.dma_len_reg   = r_dma_len;
    assign bus.dma_burst_reg = r_dma_burst;
    assign bus.dma_ctrl_reg  = (r_state == S_LAUNCH) ? (DATA_WIDTH'(1) << CTRL_START_BIT) : '0;
    assign bus.ch_done       = w_retire_mask;
    assign bus.ch_err        = r_ch_err;
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.active_ch     = r_active_ch;

endmodule

`default_nettype wire

// File: tb/tb_dma_channel_scheduler.sv
// ============================================================================
//  Module   : tb_dma_channel_scheduler
//  Purpose  : Directed self-checking bench for dma_channel_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_channel_scheduler;
    import dma_pkg::*;

    localparam int NUM_CH = 4;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int TO     = 16;

    logic ACLK    = 1'b0;
    logic ARESETN = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    always #5 ACLK = ~ACLK;

    dma_channel_scheduler_if #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef DMA_SCHED_TIMEOUT_EN
    logic timeout_flag;
`endif

    dma_channel_scheduler #(
        .NUM_CH         (NUM_CH),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
`ifdef DMA_SCHED_TIMEOUT_EN
        .timeout_flag (timeout_flag),
`endif
        .bus          (bus)
    );

    typedef struct {
        int          ch;
        logic [31:0] src;
        logic [31:0] dst;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic        err;
        logic [31:0] exp_len_reg;
        logic        exp_ch_err;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_desc(input int ch, input logic [31:0] src, input logic [31:0] dst,
                            input logic [7:0] len, input logic [1:0] burst);
        bus.req_src[ch*AW +: AW] = src;
        bus.req_dst[ch*AW +: AW] = dst;
        bus.req_len[ch*8 +: 8]   = len;
        bus.req_burst[ch*2 +: 2] = burst;
    endtask

    task automatic offer(input logic [NUM_CH-1:0] mask);
        bus.req_valid = mask;
        tick();
        bus.req_valid = '0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!bus.dma_ctrl_reg[CTRL_START_BIT] && n < 40) begin
            tick();
            n++;
        end
        check({name, "_start_seen"}, 64'(bus.dma_ctrl_reg[CTRL_START_BIT]), 64'd1);
    endtask

    task automatic service(input int ch, input logic [7:0] len);
        wait_start("rr");
        check("rr_active_ch", 64'(bus.active_ch), 64'(ch));
        check("rr_len", 64'(bus.dma_len_reg), 64'(len));
        bus.dma_done = 1'b0;
        bus.dma_err  = 1'b0;
        repeat (3) tick();
        bus.dma_done = 1'b1;
        tick();
        check("rr_ch_done", 64'(bus.ch_done), 64'(1 << ch));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int starts;
        int pulses;

        vecs[0] = '{ch:1, src:32'h0000_1000, dst:32'h0000_2000, len:8'd4,   burst:BURST_INCR,
                    err:1'b0, exp_len_reg:32'd4,   exp_ch_err:1'b0};
        vecs[1] = '{ch:2, src:32'h3000_0040, dst:32'h4000_0000, len:8'd255, burst:BURST_WRAP,
                    err:1'b1, exp_len_reg:32'd255, exp_ch_err:1'b1};
        vecs[2] = '{ch:2, src:32'h0000_0010, dst:32'h0000_0020, len:8'd1,   burst:BURST_FIXED,
                    err:1'b0, exp_len_reg:32'd1,   exp_ch_err:1'b0};
        vecs[3] = '{ch:3, src:32'hDEAD_BEE0, dst:32'h1234_5678, len:8'd16,  burst:BURST_INCR,
                    err:1'b0, exp_len_reg:32'd16,  exp_ch_err:1'b0};

        bus.req_valid = '0;
        bus.req_src   = '0;
        bus.req_dst   = '0;
        bus.req_len   = '0;
        bus.req_burst = '0;
        bus.dma_done  = 1'b0;
        bus.dma_err   = 1'b0;

        // Reset state
        #12;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'hF);
        check("rst_ctrl", 64'(bus.dma_ctrl_reg), 64'd0);
        check("rst_ch_err", 64'(bus.ch_err), 64'd0);
        check("rst_active", 64'(bus.active_ch), 64'd0);
        check("rst_len", 64'(bus.dma_len_reg), 64'd0);
        @(posedge ACLK);
        #1 ARESETN = 1'b1;
        tick();

        // Single-channel transfers from the vector table
        for (int v = 0; v < 4; v++) begin
            set_desc(vecs[v].ch, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].burst);
            offer(4'(1 << vecs[v].ch));
            check("vec_ready_low", 64'(bus.req_ready[vecs[v].ch]), 64'd0);
            check("vec_err_cleared", 64'(bus.ch_err[vecs[v].ch]), 64'd0);
            check("vec_no_early_start", 64'(bus.dma_ctrl_reg), 64'd0);
            tick();
            check("vec_start", 64'(bus.dma_ctrl_reg), 64'd1);
            check("vec_active", 64'(bus.active_ch), 64'(vecs[v].ch));
            check("vec_src", 64'(bus.dma_src_reg), 64'(vecs[v].src));
            check("vec_dst", 64'(bus.dma_dst_reg), 64'(vecs[v].dst));
            check("vec_len", 64'(bus.dma_len_reg), 64'(vecs[v].exp_len_reg));
            check("vec_burst", 64'(bus.dma_burst_reg), 64'(vecs[v].burst));
            check("vec_busy", 64'(bus.busy), 64'd1);
            bus.dma_done = 1'b0;
            bus.dma_err  = 1'b0;
            tick();
            check("vec_start_one_cycle", 64'(bus.dma_ctrl_reg), 64'd0);
            repeat (10) tick();
            check("vec_no_retire_yet", 64'(bus.ch_done), 64'd0);
            bus.dma_done = 1'b1;
            bus.dma_err  = vecs[v].err;
            tick();
            check("vec_ch_done", 64'(bus.ch_done), 64'(1 << vecs[v].ch));
            tick();
            check("vec_done_pulse_end", 64'(bus.ch_done), 64'd0);
            check("vec_ch_err", 64'(bus.ch_err[vecs[v].ch]), 64'(vecs[v].exp_ch_err));
            check("vec_idle", 64'(bus.busy), 64'd0);
            check("vec_ready_back", 64'(bus.req_ready[vecs[v].ch]), 64'd1);
            check("vec_len_hold", 64'(bus.dma_len_reg), 64'(vecs[v].exp_len_reg));
            bus.dma_err = 1'b0;
        end

        // Round-robin: 0,2,3 together; re-offer 0 while 3 still pending
        for (int c = 0; c < NUM_CH; c++) begin
            set_desc(c, 32'h100 * c, 32'h200 * c, 8'(c + 1), BURST_INCR);
        end
        offer(4'b1101);
        service(0, 8'd1);
        offer(4'b0001);
        service(2, 8'd3);
        service(3, 8'd4);
        service(0, 8'd1);

        // Stale done: dma_done stays high from the previous transfer
        set_desc(1, 32'h5000, 32'h6000, 8'd3, BURST_INCR);
        offer(4'b0010);
        wait_start("stale");
        pulses = 0;
        repeat (6) begin
            tick();
            if (bus.ch_done != '0) pulses++;
        end
        check("stale_no_retire", 64'(pulses), 64'd0);
        check("stale_busy", 64'(bus.busy), 64'd1);
        bus.dma_done = 1'b0;
        tick();
        bus.dma_done = 1'b1;
        tick();
        check("stale_retire", 64'(bus.ch_done), 64'b0010);
        tick();

        // Zero length on channel 3: retire with error, no launch
        set_desc(3, 32'h7000, 32'h8000, 8'd0, BURST_INCR);
        offer(4'b1000);
        tick();
        check("zero_ch_done", 64'(bus.ch_done), 64'b1000);
        check("zero_no_start", 64'(bus.dma_ctrl_reg), 64'd0);
        tick();
        check("zero_ch_err", 64'(bus.ch_err[3]), 64'd1);
        check("zero_idle", 64'(bus.busy), 64'd0);

        // Reset mid-transfer
        bus.dma_done = 1'b0;
        set_desc(0, 32'h9000, 32'hA000, 8'd8, BURST_INCR);
        offer(4'b0001);
        wait_start("rstmid");
        tick();
        check("rstmid_busy_before", 64'(bus.busy), 64'd1);
        ARESETN = 1'b0;
        #1;
        check("rstmid_busy", 64'(bus.busy), 64'd0);
        check("rstmid_pending", 64'(bus.req_ready), 64'hF);
        check("rstmid_ctrl", 64'(bus.dma_ctrl_reg), 64'd0);
        check("rstmid_ch_err", 64'(bus.ch_err), 64'd0);
        @(posedge ACLK);
        #1 ARESETN = 1'b1;
        starts = 0;
        repeat (6) begin
            tick();
            if (bus.dma_ctrl_reg[CTRL_START_BIT]) starts++;
        end
        check("rstmid_no_start", 64'(starts), 64'd0);
        check("rstmid_idle", 64'(bus.busy), 64'd0);

`ifdef DMA_SCHED_TIMEOUT_EN
        // Watchdog: no done edge after launch
        set_desc(1, 32'hB000, 32'hC000, 8'd2, BURST_INCR);
        offer(4'b0010);
        wait_start("to");
        repeat (TO) tick();
        check("to_not_yet", 64'(bus.ch_done), 64'd0);
        check("to_flag_low", 64'(timeout_flag), 64'd0);
        tick();
        check("to_ch_done", 64'(bus.ch_done), 64'b0010);
        check("to_flag", 64'(timeout_flag), 64'd1);
        tick();
        check("to_ch_err", 64'(bus.ch_err[1]), 64'd1);
        check("to_flag_sticky", 64'(timeout_flag), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
